// File: rtl/fs_cap_mc.sv
// Multi-channel frame-sync capture: per-channel VS synchroniser, glitch filter,
// selectable edge detect, frame counter and sticky frame-timeout watchdog.
module fs_cap_mc #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TO_W        = 24
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [CH_NUM-1:0]         vs_i,
  input  logic [CH_NUM-1:0]         en_i,
  input  logic [CH_NUM-1:0]         edge_sel_i,
  input  logic [CH_NUM-1:0]         clr_i,
  input  logic [TO_W-1:0]           to_limit_i,
  output logic [CH_NUM-1:0]         fs_cap_o,
  output logic [CH_NUM*CNT_W-1:0]   fs_cnt_o,
  output logic [CH_NUM-1:0]         to_o
);

  localparam int unsigned INIT_CYC = SYNC_STAGES + 2;
  localparam int unsigned IC_W     = $clog2(INIT_CYC);
  localparam int unsigned FC_W     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [IC_W-1:0]   init_cnt_q, init_cnt_d;
  logic              in_init_c;

  // Shared startup sequencer: hold filters transparent until the sync chains are primed
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == IC_W'(INIT_CYC - 1)) state_d = ST_RUN;
        else                                   init_cnt_d = init_cnt_q + IC_W'(1);
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign in_init_c = (state_q == ST_INIT);

  for (genvar ch = 0; ch < int'(CH_NUM); ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_c;
    logic                   filt_q, filt_d;
    logic                   fdly_q, fdly_d;
    logic [FC_W-1:0]        fcnt_q, fcnt_d;
    logic                   edge_c;
    logic                   cap_q, cap_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TO_W-1:0]        tcnt_q, tcnt_d;
    logic                   to_q, to_d;

    assign s_c = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        sync_q <= '0;
        filt_q <= 1'b0;
        fdly_q <= 1'b0;
        fcnt_q <= '0;
        cap_q  <= 1'b0;
        cnt_q  <= '0;
        tcnt_q <= '0;
        to_q   <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], vs_i[ch]};
        filt_q <= filt_d;
        fdly_q <= fdly_d;
        fcnt_q <= fcnt_d;
        cap_q  <= cap_d;
        cnt_q  <= cnt_d;
        tcnt_q <= tcnt_d;
        to_q   <= to_d;
      end
    end

    // Accept a new level only after FILT_LEN consecutive differing samples
    always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      fdly_d = filt_q;
      if (in_init_c) begin
        filt_d = s_c;
        fdly_d = s_c;
      end else if (s_c != filt_q) begin
        if (fcnt_q == FC_W'(FILT_LEN - 1)) filt_d = s_c;
        else                               fcnt_d = fcnt_q + FC_W'(1);
      end
    end

    assign edge_c = ~in_init_c & en_i[ch] &
                    (edge_sel_i[ch] ? (fdly_q & ~filt_q) : (filt_q & ~fdly_q));

    // Clear beats counting; a coincident pulse is still emitted but not counted
    always_comb begin
      cap_d  = edge_c;
      cnt_d  = cnt_q;
      tcnt_d = tcnt_q;
      to_d   = to_q;
      if (clr_i[ch]) begin
        cnt_d  = '0;
        tcnt_d = '0;
        to_d   = 1'b0;
      end else if (!en_i[ch]) begin
        tcnt_d = '0;
      end else begin
        if (edge_c) begin
          cnt_d  = cnt_q + CNT_W'(1);
          tcnt_d = '0;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
        if ((to_limit_i != '0) && (tcnt_d == to_limit_i)) to_d = 1'b1;
      end
    end

    assign fs_cap_o[ch]                  = cap_q;
    assign fs_cnt_o[ch*CNT_W +: CNT_W]   = cnt_q;
    assign to_o[ch]                      = to_q;
  end

endmodule

// File: doc/fs_cap_mc.md
# fs_cap_mc

Multi-channel, parametrised frame-sync capture block for the video DMA frame-buffer path. Each channel synchronises an asynchronous VS input, glitch-filters it, detects a selectable edge and emits a one-cycle frame-start pulse. Each channel also keeps a frame counter and a frame-timeout watchdog. It sits between the video input ports and the per-channel frame-buffer write controllers.

## Interface
- CH_NUM, 4: number of independent channels (1..16)
- SYNC_STAGES, 3: synchroniser flops per channel (>=2)
- FILT_LEN, 4: consecutive stable cycles required to accept a level change (>=1; 1 = no filtering)
- CNT_W, 16: frame counter width per channel
- TO_W, 24: timeout counter width
- clk_i  in  1  sole clock
- rstn_i  in  1  reset, asynchronous, active-low
- vs_i  in  CH_NUM  asynchronous VS per channel
- en_i  in  CH_NUM  channel enable (clk_i domain)
- edge_sel_i  in  CH_NUM  0 = rising edge is frame start, 1 = falling edge
- clr_i  in  CH_NUM  synchronous clear of that channel's frame counter, timeout counter and timeout flag
- to_limit_i  in  TO_W  timeout threshold in cycles, shared; 0 disables timeout
- fs_cap_o  out  CH_NUM  one-cycle frame-start pulse
- fs_cnt_o  out  CH_NUM*CNT_W  frame counters, channel n at bits [n*CNT_W +: CNT_W]
- to_o  out  CH_NUM  sticky timeout flag

## Operation
- Reset: all flops are 0. Outputs fs_cap_o=0, fs_cnt_o=0, to_o=0. The startup FSM enters INIT.
- Startup FSM (shared), states INIT -> RUN:
  - INIT lasts exactly SYNC_STAGES+2 cycles after reset release, counted by an internal counter.
  - In INIT, the filtered level is loaded directly from the last sync stage every cycle, filter counters are held at 0, and no edges are reported.
  - RUN is permanent until the next reset. A VS that is static high at reset release therefore produces no pulse.
- Per-channel pipeline: sync chain of SYNC_STAGES flops -> filter -> edge detect -> registered pulse.
- Filter:
  - While the sync output s differs from the filtered level f, a counter increments.
  - When the counter would reach FILT_LEN, f takes the value of s and the counter returns to 0.
  - Any cycle with s==f returns the counter to 0, so shorter glitches are rejected.
- Edge detect: on f rising (edge_sel_i=0) or f falling (edge_sel_i=1), compared against f delayed by one cycle. The pulse is registered into fs_cap_o.
- edge_sel_i is sampled at the edge-detect stage. Changing it mid-frame takes effect from the next f transition and never creates a pulse by itself.
- en_i low:
  - The sync chain and filter keep running.
  - fs_cap_o is held at 0, the frame counter is held, and the timeout counter is held at 0.
  - to_o is not set while en_i is low but keeps its value.
- Frame counter: increments by 1 on each emitted pulse and wraps modulo 2^CNT_W (all-ones -> 0).
- Timeout counter:
  - Increments each enabled cycle with no pulse and saturates at all-ones.
  - Resets to 0 on a pulse.
  - to_o sets on the edge where the counter becomes equal to to_limit_i (to_limit_i != 0), and stays set until clr_i or reset.
  - A later pulse does not clear to_o.
- clr_i priority:
  - clr_i overrides increment: the frame counter becomes 0, the timeout counter becomes 0 and to_o becomes 0 in the same cycle.
  - A pulse coincident with clr_i is still output on fs_cap_o, but is not counted.
- Asynchronous reset mid-frame: all state clears immediately and INIT restarts on release.

## Timing
- Latency: a vs_i transition first captured at edge 0 (and stable) produces fs_cap_o high for the cycle after edge SYNC_STAGES+FILT_LEN. With defaults, that is high in the cycle after edge 7.
- fs_cnt_o updates on the same edge that raises fs_cap_o.
- Minimum accepted VS pulse width: FILT_LEN cycles. Width FILT_LEN-1 is always rejected.
- Pulses on different channels are independent and may coincide.
- fs_cap_o never exceeds one cycle per f transition.

## Test plan
- Reset release with vs_i[0]=1 static, edge_sel=0 -> no pulse; after a clean 0->1 transition, a single pulse at SYNC_STAGES+FILT_LEN cycles (7 with defaults), fs_cnt ch0 = 1.
- 3-cycle glitch (FILT_LEN=4) on ch1 -> no pulse and no count change; a 4-cycle-wide pulse -> exactly one pulse.
- edge_sel=1 on ch2, 10 frames of VS -> 10 pulses on falling edges only; preload the counter near all-ones via 2^CNT_W frames (CNT_W=4 build) -> wraps 15 -> 0.
- to_limit_i=100, en ch3, no VS -> to_o[3] rises after exactly 100 cycles; a following VS pulse keeps to_o=1; clr_i -> to_o=0, count=0.
- clr_i asserted in the same cycle as a ch0 pulse -> fs_cap_o=1 and fs_cnt=0; en_i low during 5 frames -> no pulses, counter unchanged.
- Assert rstn_i mid-filter on all 4 channels -> outputs 0 immediately; on release there is no pulse during the INIT cycles (SYNC_STAGES+2).
